// File: rtl/uart_pwm_pkg.sv
// Shared encodings, ASCII constants and hex helpers for the UART-to-PWM command path.
package uart_pwm_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_CH,
    P_HI,
    P_LO,
    P_EOL,
    P_SKIP,
    P_EXEC
  } parse_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_WAIT
  } tx_state_e;

  localparam logic [7:0] CHR_W  = 8'h57;
  localparam logic [7:0] CHR_R  = 8'h52;
  localparam logic [7:0] CHR_K  = 8'h4B;
  localparam logic [7:0] CHR_Q  = 8'h3F;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_0  = 8'h30;

  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned QLEN_W      = 3;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, c[3:0] + 4'd9};
    end else begin
      return 5'b0;
    end
  endfunction

  function automatic logic [7:0] hex_encode(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Four-byte reply queue that feeds the UART one byte per transmit handshake.
module uart_tx_seq
  import uart_pwm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [8*QUEUE_DEPTH-1:0] load_data,
  input  logic [QLEN_W-1:0]        load_len,
  input  logic                     tx_busy,
  output logic                     busy,
  output logic                     tx_transmit,
  output logic [7:0]               tx_byte
);

  tx_state_e         tstate_q;
  logic [7:0]        q_data_q [QUEUE_DEPTH];
  logic [QLEN_W-1:0] q_len_q;
  logic [1:0]        q_idx_q;
  logic              tx_transmit_q;
  logic [7:0]        tx_byte_q;

  assign busy        = (q_len_q != '0);
  assign tx_transmit = tx_transmit_q;
  assign tx_byte     = tx_byte_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tstate_q      <= T_IDLE;
      q_len_q       <= '0;
      q_idx_q       <= '0;
      tx_transmit_q <= 1'b0;
      tx_byte_q     <= 8'h00;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data_q[i] <= 8'h00;
      end
    end else begin
      // Load and pop are exclusive: a load only lands in an empty queue.
      if (load && q_len_q == '0) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          q_data_q[i] <= load_data[8*i +: 8];
        end
        q_len_q <= load_len;
        q_idx_q <= '0;
      end
      case (tstate_q)
        T_IDLE: begin
          if (q_len_q != '0) begin
            tx_byte_q     <= q_data_q[q_idx_q];
            tx_transmit_q <= 1'b1;
            tstate_q      <= T_REQ;
          end
        end
        T_REQ: begin
          // Release the request as soon as the UART has taken the byte.
          if (tx_busy) begin
            tx_transmit_q <= 1'b0;
            tstate_q      <= T_WAIT;
          end
        end
        T_WAIT: begin
          if (!tx_busy) begin
            if ({1'b0, q_idx_q} + 3'd1 == q_len_q) begin
              q_len_q <= '0;
              q_idx_q <= '0;
            end else begin
              q_idx_q <= q_idx_q + 2'd1;
            end
            tstate_q <= T_IDLE;
          end
        end
        default: tstate_q <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_pwm_cmd.sv
// ASCII command parser that writes/reads PWM duty registers and queues a short reply.
module uart_pwm_cmd
  import uart_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DUTY_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_received,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_error,
  input  logic                     tx_busy,
  output logic                     tx_transmit,
  output logic [7:0]               tx_byte,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic                     cmd_busy,
  output logic [7:0]               cmd_count
);

  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0]  CH_LIMIT = 8'(CHR_0 + NUM_CH);

  parse_state_e             pstate_q;
  logic                     is_wr_q;
  logic [CH_W-1:0]          ch_q;
  logic [3:0]               hi_q;
  logic [3:0]               lo_q;
  logic [DUTY_W-1:0]        duty_q [NUM_CH];
  logic [7:0]               cmd_count_q;
  logic                     load_q;
  logic [8*QUEUE_DEPTH-1:0] load_data_q;
  logic [QLEN_W-1:0]        load_len_q;
  logic                     seq_busy;

  logic [4:0]        rx_hex;
  logic              ch_ok;
  logic [DUTY_W-1:0] rd_val;

  assign rx_hex    = hex_decode(rx_byte);
  assign ch_ok     = (rx_byte >= CHR_0) && (rx_byte < CH_LIMIT);
  assign rd_val    = duty_q[ch_q];
  assign cmd_busy  = load_q | seq_busy;
  assign cmd_count = cmd_count_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_duty
    assign duty[DUTY_W*n +: DUTY_W] = duty_q[n];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pstate_q    <= P_IDLE;
      is_wr_q     <= 1'b0;
      ch_q        <= '0;
      hi_q        <= 4'h0;
      lo_q        <= 4'h0;
      cmd_count_q <= 8'h00;
      load_q      <= 1'b0;
      load_data_q <= '0;
      load_len_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      load_q <= 1'b0;
      if (pstate_q == P_EXEC || cmd_busy) begin
        // A reply is pending or in flight: incoming traffic is dropped.
        pstate_q <= P_IDLE;
      end else if (rx_error) begin
        pstate_q    <= P_IDLE;
        load_q      <= 1'b1;
        load_data_q <= {8'h00, CHR_LF, CHR_CR, CHR_Q};
        load_len_q  <= 3'd3;
      end else if (rx_received && rx_byte != CHR_LF) begin
        case (pstate_q)
          P_IDLE: begin
            if (rx_byte == CHR_W || rx_byte == CHR_R) begin
              is_wr_q  <= (rx_byte == CHR_W);
              pstate_q <= P_CH;
            end else if (rx_byte != CHR_CR) begin
              pstate_q <= P_SKIP;
            end
          end
          P_CH: begin
            if (ch_ok) begin
              ch_q     <= rx_byte[CH_W-1:0];
              pstate_q <= is_wr_q ? P_HI : P_EOL;
            end else begin
              pstate_q <= P_SKIP;
            end
          end
          P_HI: begin
            hi_q     <= rx_hex[3:0];
            pstate_q <= rx_hex[4] ? P_LO : P_SKIP;
          end
          P_LO: begin
            lo_q     <= rx_hex[3:0];
            pstate_q <= rx_hex[4] ? P_EOL : P_SKIP;
          end
          P_EOL: begin
            if (rx_byte == CHR_CR) begin
              // Execute on the CR edge so the duty lands one clock after the strobe.
              pstate_q    <= P_EXEC;
              cmd_count_q <= cmd_count_q + 8'd1;
              load_q      <= 1'b1;
              if (is_wr_q) begin
                duty_q[ch_q] <= {hi_q, lo_q};
                load_data_q  <= {8'h00, CHR_LF, CHR_CR, CHR_K};
                load_len_q   <= 3'd3;
              end else begin
                load_data_q <= {CHR_LF, CHR_CR, hex_encode(rd_val[3:0]), hex_encode(rd_val[7:4])};
                load_len_q  <= 3'd4;
              end
            end else begin
              pstate_q <= P_SKIP;
            end
          end
          P_SKIP: begin
            if (rx_byte == CHR_CR) begin
              pstate_q    <= P_IDLE;
              load_q      <= 1'b1;
              load_data_q <= {8'h00, CHR_LF, CHR_CR, CHR_Q};
              load_len_q  <= 3'd3;
            end
          end
          default: pstate_q <= P_IDLE;
        endcase
      end
    end
  end

  uart_tx_seq u_tx_seq (
    .clk         (clk),
    .rst         (rst),
    .load        (load_q),
    .load_data   (load_data_q),
    .load_len    (load_len_q),
    .tx_busy     (tx_busy),
    .busy        (seq_busy),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte)
  );

endmodule

// File: tb/tb_uart_pwm_cmd.sv
// Directed bench for uart_pwm_cmd with a simple UART transmitter model.
module tb_uart_pwm_cmd;

  localparam int unsigned NUM_CH = 4;
  localparam logic [39:0] REP_K = {8'd3, 8'h4B, 8'h0D, 8'h0A, 8'h00};
  localparam logic [39:0] REP_Q = {8'd3, 8'h3F, 8'h0D, 8'h0A, 8'h00};

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  rx_received = 1'b0;
  logic [7:0]            rx_byte = 8'h00;
  logic                  rx_error = 1'b0;
  logic                  tx_busy = 1'b0;
  logic                  tx_transmit;
  logic [7:0]            tx_byte;
  logic [NUM_CH*8-1:0]   duty;
  logic                  cmd_busy;
  logic [7:0]            cmd_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] byte_log[$];
  int hs_err = 0;
  int stab_err = 0;
  int sent_total = 0;

  uart_pwm_cmd #(.NUM_CH(NUM_CH), .DUTY_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_received (rx_received),
    .rx_byte     (rx_byte),
    .rx_error    (rx_error),
    .tx_busy     (tx_busy),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .duty        (duty),
    .cmd_busy    (cmd_busy),
    .cmd_count   (cmd_count)
  );

  always #5 clk = ~clk;

  // UART model: busy rises 2 clk after the request and stays high 20 clk.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_transmit && !tx_busy) begin
        byte_log.push_back(tx_byte);
        sent_total++;
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        @(posedge clk);
        #1;
        if (tx_transmit) hs_err++;
        repeat (19) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  logic       prev_tx = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (tx_transmit && prev_tx && tx_byte !== held) stab_err <= stab_err + 1;
    held    <= tx_byte;
    prev_tx <= tx_transmit;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [39:0] pack_log();
    logic [39:0] r;
    r = '0;
    r[39:32] = 8'(byte_log.size());
    for (int i = 0; i < 4 && i < byte_log.size(); i++) r[31-8*i -: 8] = byte_log[i];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_received = 1'b1;
    @(posedge clk);
    #1 rx_received = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string s);
    send_str(s);
    send_byte(8'h0D);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (cmd_busy && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    tests_run++;
    if (cmd_busy) begin
      tests_failed++;
      $display("FAIL wait_done: cmd_busy=%b after %0d cycles, required 0", cmd_busy, n);
    end
    n = 0;
    while (tx_busy && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (duty !== 32'h0) begin
      tests_failed++; $display("FAIL reset_duty: got %h, required 0", duty);
    end
    tests_run++;
    if (tx_transmit !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tx_transmit: got %b, required 0", tx_transmit);
    end
    tests_run++;
    if (tx_byte !== 8'h00) begin
      tests_failed++; $display("FAIL reset_tx_byte: got %h, required 00", tx_byte);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (cmd_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_cmd_busy: got %b, required 0", cmd_busy);
    end
    tests_run++;
    if (cmd_count !== 8'd0) begin
      tests_failed++; $display("FAIL reset_cmd_count: got %0d, required 0", cmd_count);
    end
  endtask

  task automatic test_write();
    byte_log.delete();
    send_str("W2A5");
    rx_byte = 8'h0D;
    rx_received = 1'b1;
    tests_run++;
    if (duty !== 32'h0) begin
      tests_failed++; $display("FAIL write_before_edge: got %h, required 0", duty);
    end
    @(posedge clk);
    #1 rx_received = 1'b0;
    tests_run++;
    if (duty[23:16] !== 8'hA5) begin
      tests_failed++; $display("FAIL write_latency: got %h, required a5", duty[23:16]);
    end
    tests_run++;
    if (cmd_busy !== 1'b1) begin
      tests_failed++; $display("FAIL write_busy: got %b, required 1", cmd_busy);
    end
    wait_done();
    tests_run++;
    if (pack_log() !== REP_K) begin
      tests_failed++; $display("FAIL write_reply: got %h, required %h", pack_log(), REP_K);
    end
    tests_run++;
    if (cmd_count !== 8'd1) begin
      tests_failed++; $display("FAIL write_count: got %0d, required 1", cmd_count);
    end
  endtask

  task automatic test_read();
    byte_log.delete();
    send_line("R2");
    wait_done();
    tests_run++;
    if (pack_log() !== {8'd4, 8'h41, 8'h35, 8'h0D, 8'h0A}) begin
      tests_failed++; $display("FAIL read_ch2: got %h, required 0441350d0a", pack_log());
    end
    byte_log.delete();
    send_line("R0");
    wait_done();
    tests_run++;
    if (pack_log() !== {8'd4, 8'h30, 8'h30, 8'h0D, 8'h0A}) begin
      tests_failed++; $display("FAIL read_ch0: got %h, required 0430300d0a", pack_log());
    end
    tests_run++;
    if (cmd_count !== 8'd3) begin
      tests_failed++; $display("FAIL read_count: got %0d, required 3", cmd_count);
    end
  endtask

  task automatic test_bad_channel();
    byte_log.delete();
    send_line("W9ff");
    wait_done();
    tests_run++;
    if (pack_log() !== REP_Q) begin
      tests_failed++; $display("FAIL badch_reply: got %h, required %h", pack_log(), REP_Q);
    end
    tests_run++;
    if (duty !== 32'h00A50000 || cmd_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL badch_state: duty %h count %0d, required 00a50000 3", duty, cmd_count);
    end
    byte_log.delete();
    send_line("W1ff");
    wait_done();
    tests_run++;
    if (duty !== 32'h00A5FF00 || pack_log() !== REP_K) begin
      tests_failed++;
      $display("FAIL lower_hex: duty %h reply %h, required 00a5ff00 %h", duty, pack_log(), REP_K);
    end
  endtask

  task automatic test_rx_error();
    byte_log.delete();
    send_str("W1");
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_error = 1'b0;
    wait_done();
    tests_run++;
    if (pack_log() !== REP_Q) begin
      tests_failed++; $display("FAIL rxerr_reply: got %h, required %h", pack_log(), REP_Q);
    end
    // CR and framing error in the same cycle: the error must win.
    byte_log.delete();
    send_str("R1");
    rx_byte = 8'h0D;
    rx_received = 1'b1;
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_received = 1'b0;
    rx_error = 1'b0;
    wait_done();
    tests_run++;
    if (pack_log() !== REP_Q || cmd_count !== 8'd4) begin
      tests_failed++;
      $display("FAIL err_wins: reply %h count %0d, required %h 4", pack_log(), cmd_count, REP_Q);
    end
    byte_log.delete();
    send_line("R1");
    wait_done();
    tests_run++;
    if (pack_log() !== {8'd4, 8'h46, 8'h46, 8'h0D, 8'h0A} || cmd_count !== 8'd5) begin
      tests_failed++;
      $display("FAIL rxerr_read: reply %h count %0d, required 0446460d0a 5", pack_log(), cmd_count);
    end
  endtask

  task automatic test_busy_drop();
    byte_log.delete();
    send_line("W033");
    send_line("W077");
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_error = 1'b0;
    tests_run++;
    if (cmd_busy !== 1'b1) begin
      tests_failed++; $display("FAIL busy_window: cmd_busy %b, required 1", cmd_busy);
    end
    wait_done();
    tests_run++;
    if (pack_log() !== REP_K || duty[7:0] !== 8'h33 || cmd_count !== 8'd6) begin
      tests_failed++;
      $display("FAIL busy_drop: reply %h ch0 %h count %0d, required %h 33 6",
               pack_log(), duty[7:0], cmd_count, REP_K);
    end
  endtask

  task automatic test_handshake();
    tests_run++;
    if (hs_err != 0 || stab_err != 0 || sent_total < 20) begin
      tests_failed++;
      $display("FAIL handshake: hold_err %0d stab_err %0d sent %0d, required 0 0 >=20",
               hs_err, stab_err, sent_total);
    end
  endtask

  task automatic test_reset_mid_reply();
    int n;
    byte_log.delete();
    send_line("R2");
    n = 0;
    while (byte_log.size() < 2 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    tests_run++;
    if (byte_log.size() < 2) begin
      tests_failed++; $display("FAIL midrst_wait: got %0d bytes, required 2", byte_log.size());
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (tx_transmit !== 1'b0 || duty !== 32'h0 || cmd_busy !== 1'b0 || cmd_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL midrst_async: tx %b duty %h busy %b count %0d, required 0 0 0 0",
               tx_transmit, duty, cmd_busy, cmd_count);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    while (tx_busy && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (3) @(posedge clk);
    #1 byte_log.delete();
    send_line("R0");
    wait_done();
    tests_run++;
    if (pack_log() !== {8'd4, 8'h30, 8'h30, 8'h0D, 8'h0A} || cmd_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL midrst_read: reply %h count %0d, required 0430300d0a 1", pack_log(), cmd_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_channel();
    test_rx_error();
    test_busy_drop();
    test_handshake();
    test_reset_mid_reply();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
